// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU memory-stage controller.
// funct3 codes, controller state enum, legality/alignment checks.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } lsu_state_t;

   // Stores only have signed-style codes; unsigned codes are load-only.
   function automatic logic f3_legal(
      input logic       we,
      input logic [2:0] f3
   );
      logic sz_ok;
      sz_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return we ? sz_ok
                : (sz_ok || (f3 == F3_BU) || (f3 == F3_HU));
   endfunction

   function automatic logic misaligned(
      input logic [2:0] f3,
      input logic [1:0] a
   );
      logic half;
      logic word;
      half = (f3[1:0] == 2'b01);
      word = (f3[1:0] == 2'b10);
      return (half & a[0]) | (word & (|a));
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: picks byte/halfword lane and extends it.
// Ports: rdata_i raw word, a_i addr[1:0], funct3_i width code, data_o result.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  a_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = rdata_i[{a_i, 3'b000} +: 8];
      h = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      unique case (funct3_i)
         F3_B:    data_o = {{24{b[7]}}, b};
         F3_H:    data_o = {{16{h[15]}}, h};
         F3_BU:   data_o = {24'h0, b};
         F3_HU:   data_o = {16'h0, h};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// M-stage load/store controller: req/ack to dmem, lane steering, stall.
// Inputs: M-stage access (MemReq_M, MemWE_M, funct3_M, Addr_M, WriteData_M,
//   RegWE_M, A4_M), dmem_ack/dmem_rdata. Outputs: dmem_* request bundle,
//   Stall_M, ReadData/RegWE_W/A4_W to the W side, BusErr pulse.
// Option LSU_MISALIGN_TRAP_EN: traps misaligned H/W, adds MisalignErr.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter  int TIMEOUT_CYCLES = 255,
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReq_M,
   input  logic        MemWE_M,
   input  logic [2:0]  funct3_M,
   input  logic [31:0] Addr_M,
   input  logic [31:0] WriteData_M,
   input  logic        RegWE_M,
   input  logic [4:0]  A4_M,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        Stall_M,
   output logic [31:0] ReadData,
   output logic        RegWE_W,
   output logic [4:0]  A4_W,
   output logic        BusErr
`ifdef LSU_MISALIGN_TRAP_EN
   ,
   output logic        MisalignErr
`endif
);

   localparam int CW = (TO_W < 1) ? 1 : TO_W;
   localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

   lsu_state_t  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  f3_q, f3_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wd_q, wd_d;
   logic        rwe_q, rwe_d;
   logic [4:0]  a4_q, a4_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] rd_q, rd_d;
   logic        regwe_w_q, regwe_w_d;
   logic [4:0]  a4_w_q, a4_w_d;
   logic        buserr_q, buserr_d;
`ifdef LSU_MISALIGN_TRAP_EN
   logic        misal_q, misal_d;
`endif

   logic [3:0]  be_n;
   logic [31:0] wd_n;
   logic [31:0] ld_ext;
   logic [CW-1:0] cnt_inc;

   lsu_load_align u_align (
      .rdata_i  (dmem_rdata),
      .a_i      (addr_q[1:0]),
      .funct3_i (f3_q),
      .data_o   (ld_ext)
   );

   assign cnt_inc = cnt_q + 1'b1;

   // Lane steering from the incoming access; latched on IDLE->BUSY.
   always_comb begin
      be_n = 4'b1111;
      wd_n = WriteData_M;
      unique case (funct3_M[1:0])
         2'b00: begin
            be_n = 4'b0001 << Addr_M[1:0];
            wd_n = {4{WriteData_M[7:0]}};
         end
         2'b01: begin
            be_n = 4'b0011 << {Addr_M[1], 1'b0};
            wd_n = {2{WriteData_M[15:0]}};
         end
         default: begin
            be_n = 4'b1111;
            wd_n = WriteData_M;
         end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      f3_d      = f3_q;
      we_d      = we_q;
      be_d      = be_q;
      wd_d      = wd_q;
      rwe_d     = rwe_q;
      a4_d      = a4_q;
      cnt_d     = cnt_q;
      rd_d      = rd_q;
      regwe_w_d = 1'b0;
      a4_w_d    = 5'd0;
      buserr_d  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misal_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (MemReq_M) begin
               if (!f3_legal(MemWE_M, funct3_M)) begin
                  state_d  = DONE;
                  buserr_d = 1'b1;
                  a4_w_d   = A4_M;
                  rd_d     = 32'h0;
               end
`ifdef LSU_MISALIGN_TRAP_EN
               else if (misaligned(funct3_M, Addr_M[1:0])) begin
                  state_d = DONE;
                  misal_d = 1'b1;
                  a4_w_d  = A4_M;
                  rd_d    = 32'h0;
               end
`endif
               else begin
                  state_d = BUSY;
                  addr_d  = Addr_M;
                  f3_d    = funct3_M;
                  we_d    = MemWE_M;
                  be_d    = be_n;
                  wd_d    = wd_n;
                  rwe_d   = RegWE_M;
                  a4_d    = A4_M;
                  cnt_d   = '0;
               end
            end
         end
         BUSY: begin
            if (dmem_ack) begin
               state_d   = DONE;
               rd_d      = ld_ext;
               regwe_w_d = rwe_q & ~we_q;
               a4_w_d    = a4_q;
            end else if (TIMEOUT_CYCLES != 0 && cnt_inc == TO_LIM) begin
               state_d  = DONE;
               buserr_d = 1'b1;
               rd_d     = 32'h0;
               a4_w_d   = a4_q;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         addr_q    <= 32'h0;
         f3_q      <= 3'h0;
         we_q      <= 1'b0;
         be_q      <= 4'h0;
         wd_q      <= 32'h0;
         rwe_q     <= 1'b0;
         a4_q      <= 5'd0;
         cnt_q     <= '0;
         rd_q      <= 32'h0;
         regwe_w_q <= 1'b0;
         a4_w_q    <= 5'd0;
         buserr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         f3_q      <= f3_d;
         we_q      <= we_d;
         be_q      <= be_d;
         wd_q      <= wd_d;
         rwe_q     <= rwe_d;
         a4_q      <= a4_d;
         cnt_q     <= cnt_d;
         rd_q      <= rd_d;
         regwe_w_q <= regwe_w_d;
         a4_w_q    <= a4_w_d;
         buserr_q  <= buserr_d;
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) misal_q <= 1'b0;
      else        misal_q <= misal_d;
   end
   assign MisalignErr = misal_q;
`endif

   assign dmem_req   = (state_q == BUSY);
   assign dmem_we    = dmem_req & we_q;
   assign dmem_addr  = {addr_q[31:2], 2'b00};
   assign dmem_be    = be_q;
   assign dmem_wdata = wd_q;

   assign Stall_M  = ((state_q == IDLE) & MemReq_M) | (state_q == BUSY);
   assign ReadData = rd_q;
   assign RegWE_W  = regwe_w_q;
   assign A4_W     = a4_w_q;
   assign BusErr   = buserr_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: vector table plus corner sequences.
// Second instance with TIMEOUT_CYCLES=4 covers the timeout path.
module tb_lsu_mem_ctrl;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemReq_M = 1'b0;
   logic        MemWE_M = 1'b0;
   logic [2:0]  funct3_M = 3'h0;
   logic [31:0] Addr_M = 32'h0;
   logic [31:0] WriteData_M = 32'h0;
   logic        RegWE_M = 1'b0;
   logic [4:0]  A4_M = 5'd0;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = 32'h0;

   logic        dmem_req, dmem_we, Stall_M, RegWE_W, BusErr;
   logic [31:0] dmem_addr, dmem_wdata, ReadData;
   logic [3:0]  dmem_be;
   logic [4:0]  A4_W;

   logic        req_t, we_t, stall_t, regwe_t, buserr_t;
   logic [31:0] addr_t, wdata_t, rd_t;
   logic [3:0]  be_t;
   logic [4:0]  a4_t;
`ifdef LSU_MISALIGN_TRAP_EN
   logic        MisalignErr, misal_t;
`endif

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl dut (
      .clk(clk), .reset(reset),
      .MemReq_M(MemReq_M), .MemWE_M(MemWE_M), .funct3_M(funct3_M),
      .Addr_M(Addr_M), .WriteData_M(WriteData_M),
      .RegWE_M(RegWE_M), .A4_M(A4_M),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .Stall_M(Stall_M), .ReadData(ReadData), .RegWE_W(RegWE_W),
      .A4_W(A4_W), .BusErr(BusErr)
`ifdef LSU_MISALIGN_TRAP_EN
      , .MisalignErr(MisalignErr)
`endif
   );

   lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
      .clk(clk), .reset(reset),
      .MemReq_M(MemReq_M), .MemWE_M(MemWE_M), .funct3_M(funct3_M),
      .Addr_M(Addr_M), .WriteData_M(WriteData_M),
      .RegWE_M(RegWE_M), .A4_M(A4_M),
      .dmem_req(req_t), .dmem_we(we_t), .dmem_addr(addr_t),
      .dmem_be(be_t), .dmem_wdata(wdata_t),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .Stall_M(stall_t), .ReadData(rd_t), .RegWE_W(regwe_t),
      .A4_W(a4_t), .BusErr(buserr_t)
`ifdef LSU_MISALIGN_TRAP_EN
      , .MisalignErr(misal_t)
`endif
   );

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        rwe;
      logic [4:0]  a4;
      int          waits;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      logic [31:0] e_rd;
      logic        e_rwe;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(
      input logic we, input logic [2:0] f3, input logic [31:0] a,
      input logic [31:0] wd, input logic [31:0] rd, input logic rwe,
      input logic [4:0] a4, input int w, input logic [31:0] ea,
      input logic [3:0] ebe, input logic [31:0] ewd,
      input logic [31:0] erd, input logic erwe);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = a; v.wd = wd; v.rd = rd;
      v.rwe = rwe; v.a4 = a4; v.waits = w; v.e_addr = ea;
      v.e_be = ebe; v.e_wd = ewd; v.e_rd = erd; v.e_rwe = erwe;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      MemReq_M = 1'b0;
      dmem_ack = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic drive(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic rwe, input logic [4:0] a4);
      MemReq_M = 1'b1; MemWE_M = we; funct3_M = f3;
      Addr_M = a; WriteData_M = wd; RegWE_M = rwe; A4_M = a4;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int  stalls;
      logic ok;
      string tag;
      tag = $sformatf("v%0d", idx);
      @(negedge clk);
      drive(v.we, v.f3, v.addr, v.wd, v.rwe, v.a4);
      dmem_ack = 1'b0;
      #1;
      stalls = Stall_M ? 1 : 0;
      chk({tag, " req_in_idle"}, {31'h0, dmem_req}, 32'h0);
      ok = 1'b1;
      for (int c = 0; c <= v.waits; c++) begin
         @(negedge clk);
         if (Stall_M) stalls++;
         if (!dmem_req || dmem_addr !== v.e_addr || dmem_we !== v.we)
            ok = 1'b0;
         if (v.we && (dmem_be !== v.e_be || dmem_wdata !== v.e_wd))
            ok = 1'b0;
         if (c == v.waits) begin
            dmem_ack = 1'b1;
            dmem_rdata = v.rd;
         end
      end
      chk({tag, " busy_bundle"}, {31'h0, ok}, 32'h1);
      @(negedge clk);
      dmem_ack = 1'b0;
      dmem_rdata = 32'h0;
      #1;
      if (Stall_M) stalls++;
      chk({tag, " done_req"}, {31'h0, dmem_req}, 32'h0);
      chk({tag, " RegWE_W"}, {31'h0, RegWE_W}, {31'h0, v.e_rwe});
      chk({tag, " A4_W"}, {27'h0, A4_W}, {27'h0, v.a4});
      chk({tag, " BusErr"}, {31'h0, BusErr}, 32'h0);
      if (!v.we) chk({tag, " ReadData"}, ReadData, v.e_rd);
      chk({tag, " stall_cycles"}, stalls, v.waits + 2);
      @(negedge clk);
      MemReq_M = 1'b0;
      #1;
      chk({tag, " idle_RegWE_W"}, {31'h0, RegWE_W}, 32'h0);
      if (!v.we) chk({tag, " idle_ReadData_hold"}, ReadData, v.e_rd);
   endtask

   task automatic run_illegal(input logic we, input logic [2:0] f3);
      logic ok;
      @(negedge clk);
      drive(we, f3, 32'h0000_0040, 32'h1234_5678, 1'b1, 5'd6);
      #1;
      chk("ill stall_idle", {31'h0, Stall_M}, 32'h1);
      @(negedge clk);
      #1;
      ok = !dmem_req && !Stall_M && !RegWE_W && (A4_W == 5'd6);
      chk("ill done_ctrl", {31'h0, ok}, 32'h1);
      chk("ill BusErr", {31'h0, BusErr}, 32'h1);
      chk("ill ReadData", ReadData, 32'h0);
      @(negedge clk);
      MemReq_M = 1'b0;
      #1;
      chk("ill BusErr_clear", {31'h0, BusErr}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cnt;
      logic ok;

      vq.push_back(mk(0, F3_B,  32'h1003, 0, 32'h80FF_1234, 1, 5, 0,
                      32'h1000, 0, 0, 32'hFFFF_FF80, 1));
      vq.push_back(mk(1, F3_H,  32'h2002, 32'h0000_BEEF, 0, 0, 0, 4,
                      32'h2000, 4'b1100, 32'hBEEF_BEEF, 0, 0));
      vq.push_back(mk(0, F3_HU, 32'h0002, 0, 32'h8001_7FFF, 1, 7, 0,
                      32'h0000, 0, 0, 32'h0000_8001, 1));
      vq.push_back(mk(0, F3_W,  32'h0100, 0, 32'hDEAD_BEEF, 1, 31, 1,
                      32'h0100, 0, 0, 32'hDEAD_BEEF, 1));
      vq.push_back(mk(0, F3_H,  32'h0000, 0, 32'h1234_F00D, 1, 2, 2,
                      32'h0000, 0, 0, 32'hFFFF_F00D, 1));
      vq.push_back(mk(0, F3_BU, 32'h0001, 0, 32'h1234_F00D, 1, 3, 0,
                      32'h0000, 0, 0, 32'h0000_00F0, 1));
      vq.push_back(mk(1, F3_B,  32'h0101, 32'h1234_56A5, 0, 1, 4, 0,
                      32'h0100, 4'b0010, 32'hA5A5_A5A5, 0, 0));
      vq.push_back(mk(1, F3_W,  32'h0FFC, 32'hCAFE_F00D, 0, 0, 9, 3,
                      32'h0FFC, 4'b1111, 32'hCAFE_F00D, 0, 0));
      vq.push_back(mk(0, F3_W,  32'h0008, 0, 32'h1111_1111, 0, 10, 0,
                      32'h0008, 0, 0, 32'h1111_1111, 0));
      vq.push_back(mk(0, F3_B,  32'h0002, 0, 32'h0045_0000, 1, 11, 0,
                      32'h0000, 0, 0, 32'h0000_0045, 1));
      vq.push_back(mk(1, F3_H,  32'h0010, 32'h1234_ABCD, 0, 0, 12, 1,
                      32'h0010, 4'b0011, 32'hABCD_ABCD, 0, 0));
`ifndef LSU_MISALIGN_TRAP_EN
      vq.push_back(mk(0, F3_H,  32'h0003, 0, 32'hABCD_0000, 1, 13, 0,
                      32'h0000, 0, 0, 32'hFFFF_ABCD, 1));
      vq.push_back(mk(0, F3_W,  32'h0007, 0, 32'h0102_0304, 1, 14, 0,
                      32'h0004, 0, 0, 32'h0102_0304, 1));
`endif

      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      ok = !dmem_req && !Stall_M && !RegWE_W && !BusErr && (A4_W == 5'd0);
      chk("reset ctrl_outputs", {31'h0, ok}, 32'h1);
      chk("reset ReadData", ReadData, 32'h0);

      for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

      run_illegal(1'b0, 3'b011);
      run_illegal(1'b0, 3'b110);
      run_illegal(1'b1, F3_BU);

      do_reset();
      run_vec(mk(0, F3_W, 32'h0200, 0, 32'h5A5A_5A5A, 1, 8, 0,
                 32'h0200, 0, 0, 32'h5A5A_5A5A, 1), 100);
      @(negedge clk);
      drive(1'b0, F3_W, 32'h0040, 32'h0, 1'b1, 5'd15);
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (req_t) cnt++;
         if (buserr_t) break;
      end
      chk("to busy_cycles", cnt, 4);
      chk("to BusErr", {31'h0, buserr_t}, 32'h1);
      chk("to ReadData", rd_t, 32'h0);
      chk("to RegWE_W", {31'h0, regwe_t}, 32'h0);
      chk("to done_req", {31'h0, req_t}, 32'h0);
      @(negedge clk);
      MemReq_M = 1'b0;
      #1;
      ok = !buserr_t && !stall_t && !req_t;
      chk("to back_idle", {31'h0, ok}, 32'h1);

      do_reset();
      @(negedge clk);
      drive(1'b0, F3_W, 32'h0080, 32'h0, 1'b1, 5'd20);
      repeat (2) @(negedge clk);
      chk("rst busy_req", {31'h0, dmem_req}, 32'h1);
      reset = 1'b0;
      MemReq_M = 1'b0;
      #1;
      chk("rst req_drop", {31'h0, dmem_req}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      ok = 1'b1;
      for (int c = 0; c < 3; c++) begin
         dmem_ack = 1'b1;
         dmem_rdata = 32'hFFFF_FFFF;
         @(negedge clk);
         if (dmem_req || Stall_M || RegWE_W || BusErr) ok = 1'b0;
         if (ReadData !== 32'h0) ok = 1'b0;
      end
      dmem_ack = 1'b0;
      chk("rst ack_ignored", {31'h0, ok}, 32'h1);

`ifdef LSU_MISALIGN_TRAP_EN
      @(negedge clk);
      drive(1'b0, F3_W, 32'h0006, 32'h0, 1'b1, 5'd21);
      #1;
      cnt = Stall_M ? 1 : 0;
      chk("mis req_idle", {31'h0, dmem_req}, 32'h0);
      @(negedge clk);
      #1;
      if (Stall_M) cnt++;
      chk("mis MisalignErr", {31'h0, MisalignErr}, 32'h1);
      ok = !dmem_req && !BusErr && !RegWE_W && (ReadData == 32'h0);
      chk("mis done_ctrl", {31'h0, ok}, 32'h1);
      chk("mis stall_cycles", cnt, 1);
      @(negedge clk);
      MemReq_M = 1'b0;
      #1;
      chk("mis clear", {31'h0, MisalignErr}, 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
